// File: rtl/if_id_pipe_reg.sv
// ---------------------------------------------------------------------------
// if_id_pipe_reg
//   IF/ID pipeline register with a valid/ready handshake and a 2-entry skid
//   buffer. It carries the fetched instruction word and its PC into decode.
//   It absorbs decode back-pressure without dropping a fetch. A flush (taken
//   branch or jump) discards all held and incoming words and leaves a NOP
//   bubble on the decode side.
//
//   Every output is driven straight from a flop, so there is no
//   combinational path from i_if_* to o_id_* or from i_id_ready to
//   o_if_ready.
//
// Optional feature (macro IF_ID_STALL_CNT_EN):
//   When this macro is defined, the module adds parameter CNT_W and output
//   o_stall_cnt. The counter counts cycles with id_valid & !id_ready,
//   saturates at its maximum value, and is cleared only by reset.
//
// Ports
//   i_clk        clock, rising edge
//   i_reset      asynchronous reset, active high
//   i_if_valid   fetch offers i_if_instr / i_if_pc
//   o_if_ready   register can accept (registered, = !FULL)
//   i_if_instr   fetched instruction
//   i_if_pc      PC of fetched instruction
//   i_flush      discard held and incoming instructions
//   o_id_valid   decode-side payload valid
//   i_id_ready   decode consumes this cycle
//   o_id_instr   instruction to decode, NOP_CODE when !o_id_valid
//   o_id_pc      PC to decode, 0 when !o_id_valid
//   o_stall_cnt  stall cycle counter (IF_ID_STALL_CNT_EN only)
//
// States
//   EMPTY | nothing held, id_valid=0
//   HALF  | main register holds the word shown to decode
//   FULL  | main and skid both hold words, if_ready=0
// ---------------------------------------------------------------------------
module if_id_pipe_reg #(
    parameter int                 INSTR_W  = 8,
    parameter int                 PC_W     = 8,
    parameter logic [INSTR_W-1:0] NOP_CODE = '0
`ifdef IF_ID_STALL_CNT_EN
    ,
    parameter int                 CNT_W    = 16
`endif
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_if_valid,
    output logic               o_if_ready,
    input  logic [INSTR_W-1:0] i_if_instr,
    input  logic [PC_W-1:0]    i_if_pc,
    input  logic               i_flush,
    output logic               o_id_valid,
    input  logic               i_id_ready,
    output logic [INSTR_W-1:0] o_id_instr,
    output logic [PC_W-1:0]    o_id_pc
`ifdef IF_ID_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]   o_stall_cnt
`endif
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] HALF  = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]         r_state;
    logic               r_if_ready;
    logic               r_id_valid;
    logic [INSTR_W-1:0] r_main_instr;
    logic [PC_W-1:0]    r_main_pc;
    logic [INSTR_W-1:0] r_skid_instr;
    logic [PC_W-1:0]    r_skid_pc;

    logic w_acc;
    logic w_pop;

    assign w_acc = i_if_valid & r_if_ready;
    assign w_pop = r_id_valid & i_id_ready;

    assign o_if_ready = r_if_ready;
    assign o_id_valid = r_id_valid;
    assign o_id_instr = r_main_instr;
    assign o_id_pc    = r_main_pc;

    // The main register is forced back to NOP_CODE/0 whenever the state drops
    // to EMPTY. This keeps the idle payload right without an output mux.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= EMPTY;
            r_if_ready   <= 1'b1;
            r_id_valid   <= 1'b0;
            r_main_instr <= NOP_CODE;
            r_main_pc    <= '0;
            r_skid_instr <= NOP_CODE;
            r_skid_pc    <= '0;
        end else if (i_flush) begin
            r_state      <= EMPTY;
            r_if_ready   <= 1'b1;
            r_id_valid   <= 1'b0;
            r_main_instr <= NOP_CODE;
            r_main_pc    <= '0;
            r_skid_instr <= NOP_CODE;
            r_skid_pc    <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_acc) begin
                        r_state      <= HALF;
                        r_id_valid   <= 1'b1;
                        r_main_instr <= i_if_instr;
                        r_main_pc    <= i_if_pc;
                    end
                end
                HALF: begin
                    if (w_acc && w_pop) begin
                        r_main_instr <= i_if_instr;
                        r_main_pc    <= i_if_pc;
                    end else if (w_acc) begin
                        r_state      <= FULL;
                        r_if_ready   <= 1'b0;
                        r_skid_instr <= i_if_instr;
                        r_skid_pc    <= i_if_pc;
                    end else if (w_pop) begin
                        r_state      <= EMPTY;
                        r_id_valid   <= 1'b0;
                        r_main_instr <= NOP_CODE;
                        r_main_pc    <= '0;
                    end
                end
                FULL: begin
                    if (w_pop) begin
                        r_state      <= HALF;
                        r_if_ready   <= 1'b1;
                        r_main_instr <= r_skid_instr;
                        r_main_pc    <= r_skid_pc;
                    end
                end
                default: begin
                    r_state      <= EMPTY;
                    r_if_ready   <= 1'b1;
                    r_id_valid   <= 1'b0;
                    r_main_instr <= NOP_CODE;
                    r_main_pc    <= '0;
                end
            endcase
        end
    end

`ifdef IF_ID_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    // The counter is not cleared by flush, so it keeps counting stalls
    // across branch redirects.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_stall_cnt <= '0;
        end else if (r_id_valid && !i_id_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_if_id_pipe_reg.sv
module tb_if_id_pipe_reg;

    logic       clk;
    logic       reset;
    logic       if_valid;
    logic       if_ready;
    logic [7:0] if_instr;
    logic [7:0] if_pc;
    logic       flush;
    logic       id_valid;
    logic       id_ready;
    logic [7:0] id_instr;
    logic [7:0] id_pc;
`ifdef IF_ID_STALL_CNT_EN
    logic [3:0] stall_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;

`ifdef IF_ID_STALL_CNT_EN
    if_id_pipe_reg #(.INSTR_W(8), .PC_W(8), .NOP_CODE(8'h00), .CNT_W(4)) u_dut (
`else
    if_id_pipe_reg #(.INSTR_W(8), .PC_W(8), .NOP_CODE(8'h00)) u_dut (
`endif
        .i_clk      (clk),
        .i_reset    (reset),
        .i_if_valid (if_valid),
        .o_if_ready (if_ready),
        .i_if_instr (if_instr),
        .i_if_pc    (if_pc),
        .i_flush    (flush),
        .o_id_valid (id_valid),
        .i_id_ready (id_ready),
        .o_id_instr (id_instr),
        .o_id_pc    (id_pc)
`ifdef IF_ID_STALL_CNT_EN
        ,
        .o_stall_cnt(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] ins, input logic [7:0] pc);
        if_valid = v;
        if_instr = ins;
        if_pc    = pc;
    endtask

    initial begin
        reset    = 1'b1;
        if_valid = 1'b0;
        if_instr = 8'h00;
        if_pc    = 8'h00;
        flush    = 1'b0;
        id_ready = 1'b0;
        step();
        step();
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_instr", {24'd0, id_instr}, 32'h00);
        chk("rst_pc",    {24'd0, id_pc},    32'h00);
        reset = 1'b0;
        step();
        chk("rst_if_ready", {31'd0, if_ready}, 32'd1);

        // Streaming at full rate.
        id_ready = 1'b1;
        drive(1'b1, 8'hA1, 8'd0);
        step();
        chk("str_v0", {31'd0, id_valid}, 32'd1);
        chk("str_i0", {24'd0, id_instr}, 32'hA1);
        chk("str_p0", {24'd0, id_pc},    32'd0);
        drive(1'b1, 8'hB2, 8'd1);
        step();
        chk("str_i1", {24'd0, id_instr}, 32'hB2);
        chk("str_p1", {24'd0, id_pc},    32'd1);
        chk("str_rdy1", {31'd0, if_ready}, 32'd1);
        drive(1'b1, 8'hC3, 8'd2);
        step();
        chk("str_i2", {24'd0, id_instr}, 32'hC3);
        chk("str_p2", {24'd0, id_pc},    32'd2);
        drive(1'b0, 8'hEE, 8'hEE);
        step();
        chk("str_drain_v", {31'd0, id_valid}, 32'd0);
        chk("str_drain_i", {24'd0, id_instr}, 32'h00);
        chk("str_drain_p", {24'd0, id_pc},    32'h00);

        // Back-pressure fills the skid buffer.
        id_ready = 1'b0;
        drive(1'b1, 8'h11, 8'h10);
        step();
        chk("bp_i0",   {24'd0, id_instr}, 32'h11);
        chk("bp_rdy0", {31'd0, if_ready}, 32'd1);
        drive(1'b1, 8'h22, 8'h11);
        step();
        chk("bp_full_rdy", {31'd0, if_ready}, 32'd0);
        chk("bp_full_i",   {24'd0, id_instr}, 32'h11);
        drive(1'b1, 8'h44, 8'h44);
        step();
        chk("bp_hold_i", {24'd0, id_instr}, 32'h11);
        chk("bp_hold_p", {24'd0, id_pc},    32'h10);
        chk("bp_hold_v", {31'd0, id_valid}, 32'd1);
        drive(1'b0, 8'h00, 8'h00);
        id_ready = 1'b1;
        step();
        chk("bp_pop_i",   {24'd0, id_instr}, 32'h22);
        chk("bp_pop_p",   {24'd0, id_pc},    32'h11);
        chk("bp_pop_rdy", {31'd0, if_ready}, 32'd1);
        step();
        chk("bp_empty_v", {31'd0, id_valid}, 32'd0);

        // Flush while FULL with an incoming word.
        id_ready = 1'b0;
        drive(1'b1, 8'h11, 8'h30);
        step();
        drive(1'b1, 8'h22, 8'h31);
        step();
        chk("fl_full_rdy", {31'd0, if_ready}, 32'd0);
        drive(1'b1, 8'h33, 8'h32);
        flush = 1'b1;
        step();
        chk("fl_v",   {31'd0, id_valid}, 32'd0);
        chk("fl_i",   {24'd0, id_instr}, 32'h00);
        chk("fl_p",   {24'd0, id_pc},    32'h00);
        chk("fl_rdy", {31'd0, if_ready}, 32'd1);
        flush = 1'b0;
        drive(1'b0, 8'h00, 8'h00);
        id_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("fl_after_v", {31'd0, id_valid}, 32'd0);
            chk("fl_after_i", {24'd0, id_instr}, 32'h00);
        end

        // Flush, accept and pop in the same cycle while HALF.
        drive(1'b1, 8'h55, 8'h20);
        step();
        chk("fh_i0", {24'd0, id_instr}, 32'h55);
        drive(1'b1, 8'h66, 8'h21);
        flush = 1'b1;
        step();
        chk("fh_v", {31'd0, id_valid}, 32'd0);
        chk("fh_i", {24'd0, id_instr}, 32'h00);
        flush = 1'b0;
        drive(1'b1, 8'h77, 8'h22);
        step();
        chk("fh_next_v", {31'd0, id_valid}, 32'd1);
        chk("fh_next_i", {24'd0, id_instr}, 32'h77);
        chk("fh_next_p", {24'd0, id_pc},    32'h22);
        drive(1'b0, 8'h00, 8'h00);
        step();
        chk("fh_drain_v", {31'd0, id_valid}, 32'd0);

        // Asynchronous reset while FULL.
        id_ready = 1'b0;
        drive(1'b1, 8'h88, 8'h40);
        step();
        drive(1'b1, 8'h99, 8'h41);
        step();
        chk("ar_full_rdy", {31'd0, if_ready}, 32'd0);
        drive(1'b0, 8'h00, 8'h00);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_v", {31'd0, id_valid}, 32'd0);
        chk("ar_i", {24'd0, id_instr}, 32'h00);
        chk("ar_p", {24'd0, id_pc},    32'h00);
        step();
        reset = 1'b0;
        id_ready = 1'b1;
        step();
        chk("ar_rdy",   {31'd0, if_ready}, 32'd1);
        chk("ar_rel_v", {31'd0, id_valid}, 32'd0);

`ifdef IF_ID_STALL_CNT_EN
        chk("sc_zero", {28'd0, stall_cnt}, 32'd0);
        id_ready = 1'b0;
        drive(1'b1, 8'hAA, 8'h50);
        step();
        drive(1'b0, 8'h00, 8'h00);
        for (int k = 0; k < 20; k++) step();
        chk("sc_sat", {28'd0, stall_cnt}, 32'd15);
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        chk("sc_flush", {28'd0, stall_cnt}, 32'd15);
        chk("sc_flush_v", {31'd0, id_valid}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
